wave_mixer: RTL and testbench

WAVE_MIXER -- requirements
Module: wave_mixer

---
 rtl/wave_mixer.sv | 146 ++++++++++++++
 tb/tb_wave_mixer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wave_mixer.sv
// Multi-channel volume-scaled sample mixer: one channel per clock, gain vol/8.
// Define WAVE_MIXER_CLIP_EN to saturate the mix to 16 bits; otherwise the result wraps.
module wave_mixer #(
    parameter int NUM_CH = 8
) (
    input  logic                  I_CLK,
    input  logic                  I_RSTn,
    input  logic [16*NUM_CH-1:0]  I_SND,
    input  logic [4*NUM_CH-1:0]   I_VOL,
    input  logic [NUM_CH-1:0]     I_MUTE,
    input  logic                  I_TICK,
    output logic [15:0]           O_SND,
    output logic                  O_VALID,
    output logic                  O_CLIP,
    output logic                  O_BUSY,
    output logic                  O_OVERRUN
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [16*NUM_CH-1:0]    snd_q;
    logic [4*NUM_CH-1:0]     vol_q;
    logic [NUM_CH-1:0]       mute_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [23:0]      acc_q;
    logic [15:0]             res_q;
    logic                    res_clip_q;
    logic                    res_vld_q;
    logic [15:0]             out_snd_q;
    logic                    out_vld_q;
    logic                    out_clip_q;
    logic                    ovr_q;

    logic                    start_w;
    logic                    busy_w;
    logic signed [20:0]      prod_w [NUM_CH];
    logic signed [20:0]      cur_prod_w;
    logic signed [23:0]      acc_d;
    logic signed [20:0]      res_w;
    logic [15:0]             sat_w;
    logic                    clip_w;
    logic                    unused_bits;

    assign busy_w  = (state_q != IDLE);
    assign start_w = (state_q == IDLE) && I_TICK;

    // Volume is zero-extended so 4'hF stays positive in the signed product.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [20:0] snd_ext_w;
        logic signed [20:0] vol_ext_w;
        assign snd_ext_w  = {{5{snd_q[16*gi+15]}}, snd_q[16*gi +: 16]};
        assign vol_ext_w  = {17'd0, vol_q[4*gi +: 4]};
        assign prod_w[gi] = mute_q[gi] ? 21'sd0 : snd_ext_w * vol_ext_w;
    end

    assign cur_prod_w = prod_w[idx_q];
    assign acc_d      = acc_q + {{3{cur_prod_w[20]}}, cur_prod_w};
    assign res_w      = acc_q[23:3];

`ifdef WAVE_MIXER_CLIP_EN
    always_comb begin
        sat_w  = res_w[15:0];
        clip_w = 1'b0;
        if (res_w > 21'sd32767) begin
            sat_w  = 16'h7FFF;
            clip_w = 1'b1;
        end else if (res_w < -21'sd32768) begin
            sat_w  = 16'h8000;
            clip_w = 1'b1;
        end
    end
`else
    assign sat_w  = res_w[15:0];
    assign clip_w = 1'b0;
`endif

    assign unused_bits = ^{acc_q[2:0], res_w[20:16]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (I_TICK) state_d = ACC;
            ACC:  if (idx_q == IDX_W'(NUM_CH - 1)) state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q    <= IDLE;
            snd_q      <= '0;
            vol_q      <= '0;
            mute_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            res_clip_q <= 1'b0;
            res_vld_q  <= 1'b0;
            out_snd_q  <= '0;
            out_vld_q  <= 1'b0;
            out_clip_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovr_q     <= I_TICK && busy_w;
            res_vld_q <= (state_q == OUT);
            out_vld_q <= res_vld_q;
            if (start_w) begin
                snd_q  <= I_SND;
                vol_q  <= I_VOL;
                mute_q <= I_MUTE;
                idx_q  <= '0;
                acc_q  <= '0;
            end else if (state_q == ACC) begin
                acc_q <= acc_d;
                idx_q <= idx_q + IDX_W'(1);
            end
            if (state_q == OUT) begin
                res_q      <= sat_w;
                res_clip_q <= clip_w;
            end
            // Output register stage: O_SND only moves together with O_VALID.
            if (res_vld_q) begin
                out_snd_q  <= res_q;
                out_clip_q <= res_clip_q;
            end else begin
                out_clip_q <= 1'b0;
            end
        end
    end

    assign O_SND     = out_snd_q;
    assign O_VALID   = out_vld_q;
    assign O_CLIP    = out_clip_q;
    assign O_BUSY    = busy_w;
    assign O_OVERRUN = ovr_q;

endmodule

// File: tb/tb_wave_mixer.sv
// Directed self-checking bench for wave_mixer (NUM_CH=8); honours WAVE_MIXER_CLIP_EN.
module tb_wave_mixer;

    localparam int N = 8;

    logic            I_CLK;
    logic            I_RSTn;
    logic [16*N-1:0] I_SND;
    logic [4*N-1:0]  I_VOL;
    logic [N-1:0]    I_MUTE;
    logic            I_TICK;
    logic [15:0]     O_SND;
    logic            O_VALID;
    logic            O_CLIP;
    logic            O_BUSY;
    logic            O_OVERRUN;

    int tests_run    = 0;
    int tests_failed = 0;

    wave_mixer #(.NUM_CH(N)) dut (
        .I_CLK     (I_CLK),
        .I_RSTn    (I_RSTn),
        .I_SND     (I_SND),
        .I_VOL     (I_VOL),
        .I_MUTE    (I_MUTE),
        .I_TICK    (I_TICK),
        .O_SND     (O_SND),
        .O_VALID   (O_VALID),
        .O_CLIP    (O_CLIP),
        .O_BUSY    (O_BUSY),
        .O_OVERRUN (O_OVERRUN)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic mute_all();
        I_SND  = '0;
        I_VOL  = '0;
        I_MUTE = '1;
    endtask

    task automatic set_ch(input int n, input logic [15:0] s, input logic [3:0] v, input logic m);
        I_SND[16*n +: 16] = s;
        I_VOL[4*n +: 4]   = v;
        I_MUTE[n]         = m;
    endtask

    // Called at a negedge. Tick sampled at the next posedge (edge 0); cycle c is the
    // interval after edge c, observed at its negedge. Drives happen after sampling.
    task automatic run_pass(input string name, input int t_lo, input int t_hi,
                            input int chg_at, input logic [15:0] chg_val, input int rst_at,
                            output logic [15:0] snd, output logic clip, output int vcyc,
                            output int vcnt, output int ocnt, output logic [31:0] busy_m);
        snd = '0; clip = 1'b0; vcyc = -1; vcnt = 0; ocnt = 0; busy_m = '0;
        I_TICK = 1'b1;
        @(posedge I_CLK);
        for (int cyc = 0; cyc < 26; cyc++) begin
            @(negedge I_CLK);
            if (O_VALID) begin
                vcnt++;
                if (vcyc < 0) begin
                    vcyc = cyc;
                    snd  = O_SND;
                    clip = O_CLIP;
                end
            end
            if (O_OVERRUN) ocnt++;
            busy_m[cyc] = O_BUSY;
            I_TICK = (cyc >= t_lo) && (cyc <= t_hi);
            if (cyc == chg_at) I_SND[15:0] = chg_val;
            if (cyc == rst_at) I_RSTn = 1'b0;
            if (cyc == rst_at + 2) I_RSTn = 1'b1;
        end
        I_TICK = 1'b0;
        $display("[TB] pass %s: snd=%h clip=%0d valid_cycle=%0d valids=%0d overruns=%0d",
                 name, snd, clip, vcyc, vcnt, ocnt);
    endtask

    task automatic test_reset();
        I_RSTn = 1'b0;
        I_TICK = 1'b0;
        mute_all();
        repeat (2) @(negedge I_CLK);
        tests_run++; if (O_SND !== 16'h0000) begin tests_failed++; $display("FAIL reset_snd: got %h want 0000", O_SND); end
        tests_run++; if (O_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", O_VALID); end
        tests_run++; if (O_CLIP !== 1'b0) begin tests_failed++; $display("FAIL reset_clip: got %b want 0", O_CLIP); end
        tests_run++; if (O_BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", O_BUSY); end
        tests_run++; if (O_OVERRUN !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", O_OVERRUN); end
        I_RSTn = 1'b1;
        @(negedge I_CLK);
    endtask

    task automatic test_single();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        mute_all();
        set_ch(0, 16'h1000, 4'd8, 1'b0);
        run_pass("single", -1, -2, -1, 16'h0, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== 16'h1000) begin tests_failed++; $display("FAIL single_snd: got %h want 1000", s); end
        tests_run++; if (vc != 10) begin tests_failed++; $display("FAIL single_latency: got %0d want 10", vc); end
        tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL single_clip: got %b want 0", c); end
        tests_run++; if (vn != 1) begin tests_failed++; $display("FAIL single_valid_count: got %0d want 1", vn); end
        tests_run++; if (bm[8] !== 1'b1 || bm[9] !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got c8=%b c9=%b want 1 0", bm[8], bm[9]); end
        tests_run++; if (O_SND !== 16'h1000) begin tests_failed++; $display("FAIL single_hold: got %h want 1000", O_SND); end
    endtask

    task automatic test_clip();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        logic [15:0] exp_s; logic exp_c;
`ifdef WAVE_MIXER_CLIP_EN
        exp_s = 16'h7FFF; exp_c = 1'b1;
`else
        exp_s = 16'h0000; exp_c = 1'b0;
`endif
        for (int n = 0; n < N; n++) set_ch(n, 16'h4000, 4'd8, 1'b0);
        run_pass("clip", -1, -2, -1, 16'h0, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== exp_s) begin tests_failed++; $display("FAIL clip_snd: got %h want %h", s, exp_s); end
        tests_run++; if (c !== exp_c) begin tests_failed++; $display("FAIL clip_flag: got %b want %b", c, exp_c); end
    endtask

    task automatic test_negative();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        mute_all();
        set_ch(0, 16'hFFFF, 4'd1, 1'b0);
        run_pass("minus_one", -1, -2, -1, 16'h0, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== 16'hFFFF) begin tests_failed++; $display("FAIL neg_floor: got %h want ffff", s); end
        set_ch(0, 16'h0007, 4'd1, 1'b0);
        run_pass("small_pos", -1, -2, -1, 16'h0, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== 16'h0000) begin tests_failed++; $display("FAIL pos_floor: got %h want 0000", s); end
    endtask

    task automatic test_snapshot();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        mute_all();
        set_ch(0, 16'h0100, 4'd8, 1'b0);
        run_pass("snapshot", -1, -2, 0, 16'h7FFF, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== 16'h0100) begin tests_failed++; $display("FAIL snapshot_snd: got %h want 0100", s); end
    endtask

    task automatic test_overrun();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        mute_all();
        set_ch(0, 16'h1000, 4'd8, 1'b0);
        run_pass("overrun", 2, 2, -1, 16'h0, -10, s, c, vc, vn, on, bm);
        tests_run++; if (on != 1) begin tests_failed++; $display("FAIL overrun_count: got %0d want 1", on); end
        tests_run++; if (vn != 1) begin tests_failed++; $display("FAIL overrun_valids: got %0d want 1", vn); end
        tests_run++; if (s !== 16'h1000) begin tests_failed++; $display("FAIL overrun_snd: got %h want 1000", s); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        mute_all();
        set_ch(0, 16'h0200, 4'd8, 1'b0);
        run_pass("abort", -1, -2, -1, 16'h0, 3, s, c, vc, vn, on, bm);
        tests_run++; if (vn != 0) begin tests_failed++; $display("FAIL abort_valids: got %0d want 0", vn); end
        tests_run++; if (bm[4] !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b want 0", bm[4]); end
        tests_run++; if (O_SND !== 16'h0000) begin tests_failed++; $display("FAIL abort_snd: got %h want 0000", O_SND); end
        set_ch(0, 16'h0300, 4'd8, 1'b0);
        run_pass("after_abort", -1, -2, -1, 16'h0, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== 16'h0300 || vc != 10) begin tests_failed++; $display("FAIL after_abort: got %h at %0d want 0300 at 10", s, vc); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s; logic c; int vc, vn, on; logic [31:0] bm;
        mute_all();
        set_ch(0, 16'h0200, 4'd4, 1'b0);
        set_ch(1, 16'hFF00, 4'd3, 1'b0);
        set_ch(2, 16'h7FFF, 4'd0, 1'b0);
        set_ch(3, 16'h1234, 4'd15, 1'b1);
        run_pass("held_tick", 0, 9, -1, 16'h0200, -10, s, c, vc, vn, on, bm);
        tests_run++; if (s !== 16'h00A0) begin tests_failed++; $display("FAIL b2b_snd: got %h want 00a0", s); end
        tests_run++; if (vn != 2) begin tests_failed++; $display("FAIL b2b_valids: got %0d want 2", vn); end
        tests_run++; if (on != 9) begin tests_failed++; $display("FAIL b2b_overruns: got %0d want 9", on); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_negative();
        test_snapshot();
        test_overrun();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
